// File: rtl/text_cursor_ctrl.sv
// Keyboard-to-text-memory controller: decodes PS/2 set-2 scan bytes, tracks shift
// and the cursor, and writes ASCII characters or a full-screen blank sweep.
module text_cursor_ctrl #(
  parameter int          COLS  = 70,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_valid,
  input  logic [7:0]  scan_code,
  input  logic [7:0]  ascii_in,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic [7:0]  key_count,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, CLEAR} state_t;

  localparam logic [6:0]  COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]  ROW_MAX   = 5'(ROWS - 1);
  localparam logic [11:0] LAST_ADDR = {ROW_MAX, COL_MAX};

  state_t      state_r;
  logic        shift_held_r;
  logic        byte_valid_r;
  logic [7:0]  byte_code_r;
  logic [7:0]  byte_ascii_r;
  logic [4:0]  clr_row_r;
  logic [6:0]  clr_col_r;

  logic [4:0]  adv_row_s, ret_row_s, enter_row_s, clr_next_row_s;
  logic [6:0]  adv_col_s, ret_col_s, clr_next_col_s;
  logic [7:0]  char_s;
  logic        is_shift_s;

  // Next-position arithmetic for advance, retreat, newline and the clear sweep.
  always_comb begin
    adv_row_s      = cursor_row;
    adv_col_s      = cursor_col + 7'd1;
    ret_row_s      = cursor_row;
    ret_col_s      = cursor_col - 7'd1;
    enter_row_s    = cursor_row + 5'd1;
    clr_next_row_s = clr_row_r;
    clr_next_col_s = clr_col_r + 7'd1;
    char_s         = byte_ascii_r;
    is_shift_s     = (byte_code_r == 8'h12) || (byte_code_r == 8'h59);
    if (cursor_col == COL_MAX) begin
      adv_col_s = 7'd0;
      adv_row_s = (cursor_row == ROW_MAX) ? 5'd0 : cursor_row + 5'd1;
    end else begin
      adv_col_s = cursor_col + 7'd1;
    end
    if (cursor_col == 7'd0) begin
      ret_col_s = COL_MAX;
      ret_row_s = cursor_row - 5'd1;
    end else begin
      ret_col_s = cursor_col - 7'd1;
    end
    if (cursor_row == ROW_MAX) begin
      enter_row_s = 5'd0;
    end else begin
      enter_row_s = cursor_row + 5'd1;
    end
    if (clr_col_r == COL_MAX) begin
      clr_next_col_s = 7'd0;
      clr_next_row_s = clr_row_r + 5'd1;
    end else begin
      clr_next_col_s = clr_col_r + 7'd1;
    end
    if (shift_held_r && (byte_ascii_r >= 8'h61) && (byte_ascii_r <= 8'h7A)) begin
      char_s = byte_ascii_r - 8'h20;
    end else begin
      char_s = byte_ascii_r;
    end
  end

  // Input capture stage: decode acts on the byte one edge after it is sampled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      byte_valid_r <= 1'b0;
      byte_code_r  <= 8'h00;
      byte_ascii_r <= 8'h00;
    end else begin
      byte_valid_r <= scan_valid;
      byte_code_r  <= scan_code;
      byte_ascii_r <= ascii_in;
    end
  end

  // Decode FSM with registered write port, cursor, key counter and clear sweep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      shift_held_r <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= 12'h000;
      wr_data      <= 8'h00;
      cursor_row   <= 5'd0;
      cursor_col   <= 7'd0;
      key_count    <= 8'd0;
      busy         <= 1'b0;
      clr_row_r    <= 5'd0;
      clr_col_r    <= 7'd0;
    end else begin
      wr_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (byte_valid_r) begin
            if (byte_code_r == 8'hF0) begin
              state_r <= BRK;
            end else if (byte_code_r == 8'hE0) begin
              state_r <= EXT;
            end else if (is_shift_s) begin
              shift_held_r <= 1'b1;
            end else if (byte_code_r == 8'h76) begin
              state_r   <= CLEAR;
              busy      <= 1'b1;
              wr_en     <= 1'b1;
              wr_addr   <= 12'h000;
              wr_data   <= BLANK;
              clr_row_r <= 5'd0;
              clr_col_r <= 7'd1;
            end else if (byte_code_r == 8'h5A) begin
              cursor_col <= 7'd0;
              cursor_row <= enter_row_s;
            end else if (byte_code_r == 8'h66) begin
              if ((cursor_row != 5'd0) || (cursor_col != 7'd0)) begin
                cursor_row <= ret_row_s;
                cursor_col <= ret_col_s;
                wr_en      <= 1'b1;
                wr_addr    <= {ret_row_s, ret_col_s};
                wr_data    <= BLANK;
              end
            end else if (byte_ascii_r != 8'h00) begin
              wr_en      <= 1'b1;
              wr_addr    <= {cursor_row, cursor_col};
              wr_data    <= char_s;
              cursor_row <= adv_row_s;
              cursor_col <= adv_col_s;
              key_count  <= key_count + 8'd1;
            end
          end
        end
        BRK: begin
          if (byte_valid_r) begin
            if (is_shift_s) begin
              shift_held_r <= 1'b0;
            end
            state_r <= IDLE;
          end
        end
        EXT: begin
          if (byte_valid_r) begin
            if (byte_code_r == 8'hF0) begin
              state_r <= EXT_BRK;
            end else begin
              state_r <= IDLE;
              // Arrow keys saturate at the screen edges rather than wrapping.
              case (byte_code_r)
                8'h6B: if (cursor_col != 7'd0)  cursor_col <= cursor_col - 7'd1;
                8'h74: if (cursor_col != COL_MAX) cursor_col <= cursor_col + 7'd1;
                8'h75: if (cursor_row != 5'd0)  cursor_row <= cursor_row - 5'd1;
                8'h72: if (cursor_row != ROW_MAX) cursor_row <= cursor_row + 5'd1;
                default: ;
              endcase
            end
          end
        end
        EXT_BRK: begin
          if (byte_valid_r) begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          // wr_addr holds the cell written this cycle; stop once the last one is out.
          if (wr_addr == LAST_ADDR) begin
            busy       <= 1'b0;
            cursor_row <= 5'd0;
            cursor_col <= 7'd0;
            state_r    <= IDLE;
          end else begin
            wr_en     <= 1'b1;
            wr_addr   <= {clr_row_r, clr_col_r};
            wr_data   <= BLANK;
            clr_row_r <= clr_next_row_s;
            clr_col_r <= clr_next_col_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
